// File: rtl/adder_pkg.sv
// Shared encodings for the adder family: FSM states and add/subtract mode constants.
package adder_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/full_adder.sv
// Single-bit combinational full adder; the one arithmetic cell of the serial adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one bit per clock through a single full adder and a carry flop,
// with a start/busy/done handshake and a result register updated only on done.
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_pr;
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] w_pr_nxt;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_cout;
    logic             r_done;
    logic             w_s;
    logic             w_c;
    logic             w_last;

    full_adder u_fa (
        .a    (r_sa[0]),
        .b    (r_sb[0]),
        .cin  (r_carry),
        .sum  (w_s),
        .cout (w_c)
    );

    // New bit enters at the MSB so the LSB-first result lands aligned after WIDTH shifts.
    generate
        if (WIDTH == 1) begin : g_pr_one
            assign w_pr_nxt = w_s;
        end else begin : g_pr_wide
            assign w_pr_nxt = {w_s, r_pr[WIDTH-1:1]};
        end
    endgenerate

    assign w_last = (r_state == ST_RUN) && (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start)        w_state_nxt = ST_RUN;
            ST_RUN:  if (r_cnt == LAST) w_state_nxt = ST_IDLE;
            default:                   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sa    <= '0;
            r_sb    <= '0;
            r_pr    <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (start) begin
                    // Subtraction is a + ~b + 1: invert b and preload the carry.
                    r_sa    <= a;
                    r_sb    <= (sub == MODE_SUB) ? ~b : b;
                    r_carry <= (sub == MODE_SUB) ? 1'b1 : cin;
                    r_cnt   <= '0;
                end
            end else begin
                r_pr    <= w_pr_nxt;
                r_sa    <= r_sa >> 1;
                r_sb    <= r_sb >> 1;
                r_carry <= w_c;
                r_cnt   <= r_cnt + CW'(1);
                if (w_last) begin
                    r_sum  <= w_pr_nxt;
                    r_cout <= w_c;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign busy = (r_state == ST_RUN);
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder at WIDTH 8, 4 and 1: directed vector table, handshake, back-to-back,
// reset-abort sequences and exhaustive small-width sweeps against an arithmetic model.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       st8, st4, st1;
    logic       sub_i, cin_i;
    logic [7:0] a_i, b_i;
    logic       busy8, done8, cout8;
    logic       busy4, done4, cout4;
    logic       busy1, done1, cout1;
    logic [7:0] sum8;
    logic [3:0] sum4;
    logic [0:0] sum1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(st8), .sub(sub_i), .cin(cin_i),
        .a(a_i), .b(b_i), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));

    serial_adder #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(st4), .sub(sub_i), .cin(cin_i),
        .a(a_i[3:0]), .b(b_i[3:0]), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4));

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(st1), .sub(sub_i), .cin(cin_i),
        .a(a_i[0:0]), .b(b_i[0:0]), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1));

    typedef struct {
        logic       sub;
        logic       cin;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    // Reference: add is a+b+cin with carry at bit w; sub is a-b modulo 2^w, cout = (a >= b).
    function automatic logic [8:0] model(input int w, input logic s, input logic c,
                                         input logic [7:0] aa, input logic [7:0] bb);
        logic [7:0] mask;
        logic [8:0] t;
        logic [7:0] ma, mb;
        mask = (w == 8) ? 8'hFF : 8'((9'd1 << w) - 9'd1);
        ma = aa & mask;
        mb = bb & mask;
        if (s) begin
            t[7:0] = (ma - mb) & mask;
            t[8]   = (ma >= mb);
        end else begin
            t      = {1'b0, ma} + {1'b0, mb} + {8'd0, c};
            t[8]   = t[w];
            t[7:0] = t[7:0] & mask;
        end
        return t;
    endfunction

    function automatic logic dn(input int w);
        return (w == 8) ? done8 : (w == 4) ? done4 : done1;
    endfunction

    function automatic logic bz(input int w);
        return (w == 8) ? busy8 : (w == 4) ? busy4 : busy1;
    endfunction

    function automatic logic [7:0] sm(input int w);
        return (w == 8) ? sum8 : (w == 4) ? {4'd0, sum4} : {7'd0, sum1};
    endfunction

    function automatic logic co(input int w);
        return (w == 8) ? cout8 : (w == 4) ? cout4 : cout1;
    endfunction

    // One operation: start for one edge, then count cycles to done and busy cycles seen.
    task automatic run_op(input int w, input logic s, input logic c,
                          input logic [7:0] aa, input logic [7:0] bb,
                          output logic [7:0] rs, output logic rc, output int lat,
                          output int bcnt, output logic dafter);
        a_i = aa; b_i = bb; sub_i = s; cin_i = c;
        st8 = (w == 8); st4 = (w == 4); st1 = (w == 1);
        @(posedge clk); #1;
        st8 = 1'b0; st4 = 1'b0; st1 = 1'b0;
        lat = 0; bcnt = 0;
        while (!dn(w) && lat < 200) begin
            if (bz(w)) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        rs = sm(w);
        rc = co(w);
        @(posedge clk); #1;
        dafter = dn(w);
    endtask

    initial begin
        logic [7:0] rs;
        logic       rc, da;
        logic [8:0] e;
        int         lat, bcnt, dcnt, cyc, dat;
        logic [7:0] got33;
        logic [7:0] bb_a[5];
        logic [7:0] bb_b[5];
        logic       bb_s[5];

        vecs[0] = '{1'b0, 1'b0, 8'h5A, 8'h33, 8'h8D, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 8'h5A, 8'h33, 8'h8E, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 8'h10, 8'h01, 8'h0F, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 8'h01, 8'h02, 8'hFF, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 8'h05, 8'h05, 8'h00, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 8'h80, 8'h80, 8'h01, 1'b1};

        rst_n = 1'b0; st8 = 0; st4 = 0; st1 = 0;
        sub_i = 0; cin_i = 0; a_i = '0; b_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, busy8}, 32'd0);
        chk("reset_done", {31'd0, done8}, 32'd0);
        chk("reset_sum",  {24'd0, sum8},  32'd0);
        chk("reset_cout", {31'd0, cout8}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            run_op(8, vecs[i].sub, vecs[i].cin, vecs[i].a, vecs[i].b, rs, rc, lat, bcnt, da);
            chk($sformatf("vec%0d_sum", i),  {24'd0, rs}, {24'd0, vecs[i].exp_sum});
            chk($sformatf("vec%0d_cout", i), {31'd0, rc}, {31'd0, vecs[i].exp_cout});
            chk($sformatf("vec%0d_lat", i),  lat, 8);
            chk($sformatf("vec%0d_busy", i), bcnt, 8);
            chk($sformatf("vec%0d_donepulse", i), {31'd0, da}, 32'd0);
        end

        // Start re-asserted mid-operation with new operand A must be ignored.
        a_i = 8'h11; b_i = 8'h22; sub_i = 0; cin_i = 0; st8 = 1;
        @(posedge clk); #1;
        bcnt = 0; dcnt = 0; dat = -1; got33 = '0;
        for (int i = 0; i < 12; i++) begin
            st8 = (i == 2);
            if (i == 2) a_i = 8'hF0;
            if (busy8) bcnt++;
            if (done8) begin dcnt++; dat = i; got33 = sum8; end
            @(posedge clk); #1;
        end
        st8 = 0;
        chk("hs_sum",  {24'd0, got33}, 32'h33);
        chk("hs_busy", bcnt, 8);
        chk("hs_done", dcnt, 1);
        chk("hs_lat",  dat, 8);

        // Back-to-back with start held high: each done cycle accepts the next operands.
        bb_a = '{8'h01, 8'h7F, 8'h20, 8'hC8, 8'h00};
        bb_b = '{8'h02, 8'h01, 8'h30, 8'h64, 8'h00};
        bb_s = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0};
        a_i = bb_a[0]; b_i = bb_b[0]; sub_i = bb_s[0]; cin_i = 0; st8 = 1;
        @(posedge clk); #1;
        for (int j = 0; j < 4; j++) begin
            a_i = bb_a[j+1]; b_i = bb_b[j+1]; sub_i = bb_s[j+1];
            if (j == 3) st8 = 0;
            cyc = 0;
            while (!done8 && cyc < 50) begin
                @(posedge clk); #1;
                cyc++;
            end
            e = model(8, bb_s[j], 1'b0, bb_a[j], bb_b[j]);
            chk($sformatf("b2b%0d_sum", j),  {24'd0, sum8}, {24'd0, e[7:0]});
            chk($sformatf("b2b%0d_cout", j), {31'd0, cout8}, {31'd0, e[8]});
            chk($sformatf("b2b%0d_gap", j),  cyc, 8);
            @(posedge clk); #1;
        end
        chk("b2b_idle", {31'd0, busy8}, 32'd0);

        // Reset during RUN cycle 4 aborts without a done pulse and clears the result.
        a_i = 8'h77; b_i = 8'h11; sub_i = 0; cin_i = 0; st8 = 1;
        @(posedge clk); #1;
        st8 = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        chk("rst_busy", {31'd0, busy8}, 32'd0);
        chk("rst_sum",  {24'd0, sum8},  32'd0);
        chk("rst_cout", {31'd0, cout8}, 32'd0);
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (done8) dcnt++;
            @(posedge clk); #1;
        end
        chk("rst_nodone", dcnt, 0);
        run_op(8, 1'b0, 1'b0, 8'h01, 8'h01, rs, rc, lat, bcnt, da);
        chk("post_rst_sum",  {24'd0, rs}, 32'h02);
        chk("post_rst_cout", {31'd0, rc}, 32'd0);

        // Exhaustive sweeps for the small widths.
        foreach (bb_s[k]) bb_s[k] = 1'b0;
        for (int wi = 0; wi < 2; wi++) begin
            int w;
            w = (wi == 0) ? 4 : 1;
            for (int aa = 0; aa < (1 << w); aa++)
                for (int bb = 0; bb < (1 << w); bb++)
                    for (int s = 0; s < 2; s++)
                        for (int c = 0; c < 2; c++) begin
                            run_op(w, s[0], c[0], aa[7:0], bb[7:0], rs, rc, lat, bcnt, da);
                            e = model(w, s[0], c[0], aa[7:0], bb[7:0]);
                            chk($sformatf("w%0d_%0h_%0h_s%0d_c%0d_sum", w, aa, bb, s, c),
                                {24'd0, rs}, {24'd0, e[7:0]});
                            chk($sformatf("w%0d_%0h_%0h_s%0d_c%0d_cout", w, aa, bb, s, c),
                                {31'd0, rc}, {31'd0, e[8]});
                            chk($sformatf("w%0d_%0h_%0h_s%0d_c%0d_lat", w, aa, bb, s, c),
                                lat, w);
                        end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised bit-serial adder/subtractor: the sequential successor to the team's combinational half/full adders.
- Adds or subtracts two WIDTH-bit operands one bit per clock, using a single full_adder cell and a carry flip-flop.
- Start/busy/done handshake; a registered result.
- Used where area matters more than latency, e.g. serial datapaths and slow-rate accumulators.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..64.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  0 = a+b+cin, 1 = a-b (cin ignored); sampled with start.
- cin  input  1  carry-in for add mode; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when sum/cout are updated.
- sum  output  WIDTH  registered result; holds until the next done.
- cout  output  1  add: carry-out; sub: 1 = no borrow (a>=b unsigned).

Behaviour:
- Reset: synchronous, active-low (rst_n low at a rising clk edge). Clears state to IDLE and sets busy=0, done=0, sum=0, cout=0. Also clears the internal shift registers, carry and counter.
- FSM states: IDLE, RUN.
- IDLE -> RUN when start=1 at edge k. At that edge:
  - latch a into shift register sa;
  - latch b into sb, inverted when sub=1;
  - set carry to cin, or to 1 when sub=1;
  - clear count to 0; set busy=1.
- RUN, each edge:
  - full_adder(sa[0], sb[0], carry) produces s, c;
  - shift s into the MSB of the partial-result register pr (right shift);
  - shift sa and sb right by 1; carry <= c; count <= count+1.
- RUN -> IDLE at the edge where count == WIDTH-1 (the WIDTH-th RUN edge, edge k+WIDTH). At that edge:
  - sum <= final pr value, including the bit computed that cycle;
  - cout <= c; done <= 1; busy <= 0.
- Latency: start sampled at edge k -> done high for exactly the cycle after edge k+WIDTH.
  - busy is high for the WIDTH cycles after edges k..k+WIDTH-1.
- done is cleared at the next edge unconditionally.
- start while busy is ignored; operands are not re-sampled and the operation in progress is not disturbed.
- start high in the done cycle (state is IDLE) is accepted, so back-to-back throughput is one result per WIDTH+1 cycles.
- start held high continuously restarts on every IDLE cycle.
- sum/cout change only at the done edge or at reset; they are never visible mid-operation.
- Reset mid-RUN aborts: no done pulse; sum/cout are cleared to 0.
- WIDTH=1: RUN lasts one cycle; count is 1 bit wide, or tied to 0 if the tool requires.
- Counter width: $clog2(WIDTH) with a minimum of 1.
- Arithmetic is modulo 2^WIDTH; the carry/borrow is reported only through cout.

Decomposition:
- Shared package adder_pkg:
  - FSM state encodings (ST_IDLE=1'b0, ST_RUN=1'b1);
  - mode constants MODE_ADD=1'b0, MODE_SUB=1'b1.
- Sub-module full_adder (a, b, cin -> sum, cout), purely combinational and instantiated once. It is reused later by wider ripple blocks.
- The shift registers, counter and FSM live in serial_adder.

Test Plan:
1. WIDTH=8, add: a=8'h5A, b=8'h33, cin=0 -> done at start+8 edges, sum=8'h8D, cout=0; cin=1 instead -> sum=8'h8E, cout=0.
2. WIDTH=8, add overflow: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then sub: a=8'h10, b=8'h01 -> sum=8'h0F, cout=1; a=8'h01, b=8'h02 -> sum=8'hFF, cout=0.
3. Handshake: pulse start with a=8'h11, b=8'h22. Re-assert start at cycle 3 with a=8'hF0. -> Second start is ignored; result is 8'h33; busy is high for exactly 8 cycles; done is high for 1 cycle.
4. Back-to-back: start held high with operands changed each result. -> A new operation is accepted in every done cycle; one result per 9 cycles, each correct.
5. Reset: rst_n low for 1 edge at RUN cycle 4 -> busy=0, done never pulses, sum=0, cout=0. A following start (8'h01+8'h01) completes -> sum=8'h02.
6. WIDTH=1 and WIDTH=4: exhaustive a, b, cin, sub against a reference model -> every result matches, and done latency equals WIDTH.
